// File: rtl/matvec_engine.sv
// Fixed-point matrix-vector engine: streams row-major weights (plus optional per-row bias)
// one word per rd_valid and emits one saturated, optionally ReLU-activated element per row.
module matvec_engine #(
  parameter int DATA_W  = 16,
  parameter int FRAC_W  = 8,
  parameter int IN_LEN  = 16,
  parameter int OUT_LEN = 32,
  parameter int BIAS_EN = 1,
  parameter int ADDR_W  = 27,
  parameter int ACC_W   = 40,
  localparam int VIDX_W = (IN_LEN > 1) ? $clog2(IN_LEN) : 1,
  localparam int OIDX_W = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vec_wr_en,
  input  logic [VIDX_W-1:0] vec_wr_idx,
  input  logic [DATA_W-1:0] vec_wr_data,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_address,
  input  logic              relu_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_req,
  input  logic              rd_valid,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  output logic [OIDX_W-1:0] out_idx,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
);

  localparam int ROW_LEN = IN_LEN + BIAS_EN;
  localparam int CNT_W   = $clog2(ROW_LEN + 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, FETCH, EMIT} state_t;

  state_t                     state, state_nxt;
  logic signed [DATA_W-1:0]   vec [IN_LEN];
  logic signed [ACC_W-1:0]    acc, term, shifted;
  logic signed [2*DATA_W-1:0] prod;
  logic [CNT_W-1:0]           col;
  logic [OIDX_W-1:0]          row;
  logic                       relu_q;
  logic                       last_col, last_row, col_is_bias;
  logic [DATA_W-1:0]          act;

  assign last_col    = (col == CNT_W'(ROW_LEN - 1));
  assign last_row    = (row == OIDX_W'(OUT_LEN - 1));
  assign col_is_bias = (col >= CNT_W'(IN_LEN));

  always_comb begin
    prod    = vec[col[VIDX_W-1:0]] * $signed(rd_data);
    // Bias is an integer-aligned word, so it joins the accumulator at product scale.
    term    = col_is_bias ? (ACC_W'($signed(rd_data)) <<< FRAC_W) : ACC_W'(prod);
    shifted = acc >>> FRAC_W;
    if (shifted > SAT_MAX) begin
      act = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (shifted < SAT_MIN) begin
      act = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      act = shifted[DATA_W-1:0];
    end
    if (relu_q && act[DATA_W-1]) begin
      act = '0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FETCH;
      FETCH:   if (rd_valid && last_col) state_nxt = EMIT;
      EMIT:    state_nxt = last_row ? IDLE : FETCH;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      acc     <= '0;
      col     <= '0;
      row     <= '0;
      rd_addr <= '0;
      relu_q  <= 1'b0;
      for (int i = 0; i < IN_LEN; i++) vec[i] <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (vec_wr_en && ({1'b0, vec_wr_idx} < (VIDX_W+1)'(IN_LEN))) begin
            vec[vec_wr_idx] <= vec_wr_data;
          end
          if (start) begin
            rd_addr <= base_address;
            relu_q  <= relu_en;
            acc     <= '0;
            col     <= '0;
            row     <= '0;
          end
        end
        FETCH: begin
          // Rows are contiguous, so the next word is always the next address.
          if (rd_valid) begin
            acc     <= acc + term;
            col     <= col + CNT_W'(1);
            rd_addr <= rd_addr + ADDR_W'(1);
          end
        end
        EMIT: begin
          acc <= '0;
          col <= '0;
          if (!last_row) row <= row + OIDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign rd_req    = (state == FETCH);
  assign out_valid = (state == EMIT);
  assign busy      = (state != IDLE);
  assign done      = out_valid && last_row;
  assign out_idx   = row;
  assign out_data  = out_valid ? act : '0;

endmodule

// File: tb/tb_matvec_engine.sv
// Directed bench for matvec_engine (IN_LEN=4, OUT_LEN=2, bias on) with a memory responder
// and an arithmetic reference model checked on every out_valid.
module tb_matvec_engine;
  localparam int DW = 16, IN_LEN = 4, OUT_LEN = 2, ROW_LEN = 5, AW = 27;

  logic          clk = 0, reset = 1;
  logic          vec_wr_en = 0, start = 0, relu_en = 0, rd_valid = 0;
  logic [1:0]    vec_wr_idx = 0;
  logic [DW-1:0] vec_wr_data = 0, rd_data = 0;
  logic [AW-1:0] base_address = 0;
  logic [AW-1:0] rd_addr;
  logic          rd_req, out_valid, busy, done;
  logic [0:0]    out_idx;
  logic [DW-1:0] out_data;

  matvec_engine #(.DATA_W(DW), .FRAC_W(8), .IN_LEN(IN_LEN), .OUT_LEN(OUT_LEN), .BIAS_EN(1),
                  .ADDR_W(AW), .ACC_W(40)) dut (
    .clk(clk), .reset(reset), .vec_wr_en(vec_wr_en), .vec_wr_idx(vec_wr_idx),
    .vec_wr_data(vec_wr_data), .start(start), .base_address(base_address), .relu_en(relu_en),
    .rd_addr(rd_addr), .rd_req(rd_req), .rd_valid(rd_valid), .rd_data(rd_data),
    .out_valid(out_valid), .out_idx(out_idx), .out_data(out_data), .busy(busy), .done(done));

  always #5 clk = ~clk;

  typedef struct { int idx; int data; bit last; } exp_t;

  int            n_checks = 0, n_errors = 0;
  logic [DW-1:0] mem [0:1023];
  logic [DW-1:0] vec_m [IN_LEN];
  exp_t          exp_q[$];
  int            addr_log[$];
  int            captured [OUT_LEN];
  bit            stall_en = 0, spur_en = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: integer dot product, bias scaled by 2^8, floor shift, clamp, optional ReLU.
  function automatic int model_row(input int base, input int r, input bit relu);
    longint acc = 0;
    longint t;
    for (int i = 0; i < IN_LEN; i++)
      acc += longint'($signed(vec_m[i])) * longint'($signed(mem[base + r*ROW_LEN + i]));
    acc += longint'($signed(mem[base + r*ROW_LEN + IN_LEN])) * 256;
    t = acc >>> 8;
    if (t > 32767) t = 32767;
    if (t < -32768) t = -32768;
    if (relu && t < 0) t = 0;
    return int'(t) & 16'hFFFF;
  endfunction

  // Memory responder: answers each request after 0..5 cycles when stalling, checks address hold.
  initial begin : responder
    int  wait_cnt = 0;
    bit  prev_req = 0, prev_vld = 0;
    int  prev_addr = 0;
    forever begin
      @(negedge clk);
      if (rd_req && prev_req && !prev_vld && !reset) chk("addr_hold", int'(rd_addr), prev_addr);
      rd_valid = 0;
      if (rd_req && !reset) begin
        if (wait_cnt == 0) begin
          rd_valid = 1;
          rd_data  = mem[rd_addr[9:0]];
          addr_log.push_back(int'(rd_addr));
          wait_cnt = stall_en ? $urandom_range(0, 5) : 0;
        end else wait_cnt--;
      end else if (spur_en && $urandom_range(0, 1) == 1) begin
        rd_valid = 1;
        rd_data  = 16'h7777;
      end
      prev_req = rd_req; prev_vld = rd_valid; prev_addr = int'(rd_addr);
    end
  end

  initial begin : compare
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("out_idx", int'(out_idx), e.idx);
          chk("out_data", int'(out_data), e.data);
          chk("done_with_last", int'(done), int'(e.last));
          captured[e.idx] = int'(out_data);
        end
      end else if (done) chk("done_without_out_valid", 1, 0);
    end
  end

  task automatic set_row(input int base, input int r, input logic [DW-1:0] w, input logic [DW-1:0] b);
    for (int c = 0; c < IN_LEN; c++) mem[base + r*ROW_LEN + c] = w;
    mem[base + r*ROW_LEN + IN_LEN] = b;
  endtask

  task automatic wr_vec(input int idx, input logic [DW-1:0] d);
    vec_wr_en = 1; vec_wr_idx = 2'(idx); vec_wr_data = d;
    @(negedge clk);
    vec_wr_en = 0;
    vec_m[idx] = d;
  endtask

  // One pass, optionally poking start/vec_wr_en while busy (must be ignored) or writing
  // vec[3]=same_val in the start cycle (must be applied before the pass).
  task automatic run_pass(input int base, input bit relu, input bit poke, input bit same_wr,
                          input logic [DW-1:0] same_val);
    int cyc = 0;
    addr_log.delete();
    if (same_wr) begin
      vec_wr_en = 1; vec_wr_idx = 2'd3; vec_wr_data = same_val; vec_m[3] = same_val;
    end
    for (int r = 0; r < OUT_LEN; r++) exp_q.push_back('{r, model_row(base, r, relu), r == OUT_LEN-1});
    start = 1; base_address = AW'(base); relu_en = relu;
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      start = 0; vec_wr_en = 0; relu_en = 0; base_address = '0;
      if (cyc == 1) begin
        chk("busy_after_start", int'(busy), 1);
        chk("rd_req_after_start", int'(rd_req), 1);
      end
      if (poke && cyc == 3) begin
        start = 1; base_address = AW'(16'h200); vec_wr_en = 1; vec_wr_idx = 0; vec_wr_data = 16'h1234;
      end
    end
    chk("pass_completes", int'(done), 1);
    if (!stall_en && !poke) chk("pass_cycles", cyc, OUT_LEN * (ROW_LEN + 1));
    chk("addr_count", addr_log.size(), OUT_LEN * ROW_LEN);
    for (int i = 0; i < addr_log.size(); i++) chk("addr_seq", addr_log[i], base + i);
    @(negedge clk);
    chk("idle_after_done", int'(busy), 0);
    chk("exp_queue_drained", exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs();
    chk("rst_rd_req", int'(rd_req), 0);
    chk("rst_rd_addr", int'(rd_addr), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_idx", int'(out_idx), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    for (int i = 0; i < IN_LEN; i++) vec_m[i] = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs();
    reset = 0;
    @(negedge clk);

    // Reference vector and matrix.
    wr_vec(0, 16'h0100); wr_vec(1, 16'h0200); wr_vec(2, 16'hFF00); wr_vec(3, 16'h0080);
    set_row(16'h100, 0, 16'h0100, 16'h0100);
    set_row(16'h100, 1, 16'hFF00, 16'h0000);
    chk("model_pin_row0", model_row(16'h100, 0, 0), 16'h0380);
    chk("model_pin_row1", model_row(16'h100, 1, 0), 16'hFD80);

    run_pass(16'h100, 0, 0, 0, 0);
    chk("lit_row0", captured[0], 16'h0380);
    chk("lit_row1", captured[1], 16'hFD80);
    // Back-to-back with ReLU: start in the idle gap cycle after done.
    run_pass(16'h100, 1, 0, 0, 0);
    chk("lit_relu_row0", captured[0], 16'h0380);
    chk("lit_relu_row1", captured[1], 16'h0000);

    // Stalls and spurious rd_valid: same results as the clean run.
    stall_en = 1; spur_en = 1;
    run_pass(16'h100, 0, 0, 0, 0);
    chk("stall_row0", captured[0], 16'h0380);
    chk("stall_row1", captured[1], 16'hFD80);
    stall_en = 0; spur_en = 0;

    // start and vec writes while busy are ignored.
    run_pass(16'h100, 0, 1, 0, 0);
    chk("poke_row0", captured[0], 16'h0380);
    chk("poke_row1", captured[1], 16'hFD80);

    // vec write in the start cycle is applied: vec[3]=0x0180 -> row0 4.5, row1 -3.5.
    run_pass(16'h100, 0, 0, 1, 16'h0180);
    chk("samewr_row0", captured[0], 16'h0480);
    chk("samewr_row1", captured[1], 16'hFC80);

    // Saturation both ways.
    for (int i = 0; i < IN_LEN; i++) wr_vec(i, 16'h7FFF);
    set_row(16'h040, 0, 16'h7FFF, 16'h0000);
    set_row(16'h040, 1, 16'h8001, 16'h0000);
    run_pass(16'h040, 0, 0, 0, 0);
    chk("sat_pos", captured[0], 16'h7FFF);
    chk("sat_neg", captured[1], 16'h8000);

    // Mixed weights against the model, with stalls.
    for (int i = 0; i < IN_LEN; i++) wr_vec(i, 16'($urandom_range(0, 16'h0600)) - 16'h0300);
    for (int i = 0; i < OUT_LEN * ROW_LEN; i++) mem[16'h180 + i] = 16'($urandom_range(0, 16'h0800)) - 16'h0400;
    stall_en = 1;
    run_pass(16'h180, 0, 0, 0, 0);
    stall_en = 0;

    // Reset mid-FETCH: aborts, clears outputs and vector.
    set_row(16'h100, 0, 16'h0100, 16'h0100);
    set_row(16'h100, 1, 16'hFF00, 16'h0000);
    start = 1; base_address = AW'(16'h100);
    @(negedge clk); start = 0;
    repeat (2) @(negedge clk);
    reset = 1;
    exp_q.delete();
    @(negedge clk);
    check_reset_outputs();
    @(negedge clk);
    reset = 0;
    for (int i = 0; i < IN_LEN; i++) vec_m[i] = '0;
    repeat (3) @(negedge clk);
    chk("no_output_after_abort", int'(busy), 0);
    run_pass(16'h100, 0, 0, 0, 0);
    chk("cleared_vec_row0", captured[0], 16'h0100);
    chk("cleared_vec_row1", captured[1], 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
